// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL bits per CALC cycle, with single-cycle handling of divide corner cases.
module muldiv_iter_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  state_t          state_q, state_d;
  op_t             op_in, op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q, hi_n, lo_n;
  logic            neg_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;

  logic            accept, last, div_q;
  logic            a_signed, b_signed, sa, sb, neg_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res, final_res;
  logic [XLEN:0]   rem_t, sum_t;
  logic [2*XLEN-1:0] prod;

  // Accept-side decode: magnitudes, result sign and the corner cases that skip CALC.
  assign op_in    = op_t'(op_i);
  assign accept   = valid_i && (state_q == S_IDLE) && !flush_i;
  assign a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign sa       = a_signed && rs1_i[XLEN-1];
  assign sb       = b_signed && rs2_i[XLEN-1];
  assign a_mag    = sa ? -rs1_i : rs1_i;
  assign b_mag    = sb ? -rs2_i : rs2_i;
  assign neg_in   = (op_in == OP_REM) ? sa : (sa ^ sb);
  assign div_zero = op_i[2] && (rs2_i == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                    (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op_i[1] ? rs1_i : '1;
    else if (div_ovf) special_res = op_i[1] ? '0 : rs1_i;
  end

  // FSM
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Iteration: hi holds partial product / remainder, lo holds multiplier / quotient.
  assign div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_comb begin
    // NOTE: blocking assignments chain UNROLL steps within one cycle; every variable
    // written here gets a default first so no latch is inferred.
    hi_n  = hi_q;
    lo_n  = lo_q;
    rem_t = '0;
    sum_t = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div_q) begin
        rem_t = {hi_n, lo_n[XLEN-1]};
        lo_n  = {lo_n[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, opnd_q}) begin
          rem_t   = rem_t - {1'b0, opnd_q};
          lo_n[0] = 1'b1;
        end
        hi_n = rem_t[XLEN-1:0];
      end else begin
        sum_t = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opnd_q} : '0);
        lo_n  = {sum_t[0], lo_n[XLEN-1:1]};
        hi_n  = sum_t[XLEN:1];
      end
    end
  end

  // Sign correction applied to the final iteration's output.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    unique case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = neg_q ? -lo_n : lo_n;
      default:                      final_res = neg_q ? -hi_n : hi_n;
    endcase
  end

  // NOTE: working registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q   <= op_in;
      neg_q  <= neg_in;
      cnt_q  <= CW'(N - 1);
      hi_q   <= '0;
      lo_q   <= op_i[2] ? a_mag : b_mag;
      opnd_q <= op_i[2] ? b_mag : a_mag;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      rd_q <= rd_i;
      if (special) result_q <= special_res;
    end else if ((state_q == S_CALC) && last && !flush_i) begin
      result_q <= final_res;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule
